switch_debouncer: RTL and testbench

Debounce filter that consumes a raw mechanical switch input and produces a clean level plus single-cycle edge pulses for downstream logic. It sits directly downstream of the bounce measurement stage. Its run-time `stable_cycles` threshold is driven from the measured settle time plus margin, or from a constant. A saturating glitch counter exposes rejected bounces for tuning.

---
 rtl/switch_debouncer.sv | 174 +++++++++++++++++
 tb/tb_switch_debouncer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes a raw mechanical switch input, qualifies each
// candidate change for a latched number of stable cycles, and emits a clean level,
// single-cycle rise/fall pulses and a saturating count of rejected bounces.
// Optional long-press detector: define SWITCH_DEBOUNCER_LONG_PRESS_EN to build it;
// without the macro long_press is tied low.

module switch_debouncer #(
  parameter int unsigned  CLOCK_HZ             = 12_000_000,
  parameter int unsigned  SYNCHRONIZE_FF_DEPTH = 2,
  parameter int unsigned  MAX_STABLE_CYCLES    = CLOCK_HZ / 100 - 1,
  parameter int unsigned  LONG_PRESS_CYCLES    = CLOCK_HZ,
  localparam int unsigned COUNTER_BITS         = $clog2(MAX_STABLE_CYCLES + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    async_in,
  input  logic [COUNTER_BITS-1:0] stable_cycles,
  input  logic                    glitch_clear,
  output logic                    level,
  output logic                    rise,
  output logic                    fall,
  output logic                    filter_active,
  output logic [7:0]              glitch_count,
  output logic                    long_press
);

  localparam int unsigned GLITCH_BITS = 8;
  localparam logic [COUNTER_BITS-1:0] THR_MAX    = COUNTER_BITS'(MAX_STABLE_CYCLES);
  localparam logic [GLITCH_BITS-1:0]  GLITCH_MAX = '1;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_QUALIFY = 1'b1
  } state_e;

  logic [SYNCHRONIZE_FF_DEPTH-1:0] sync_q, sync_d;
  logic                            sync_in;
  state_e                          state_q, state_d;
  logic [COUNTER_BITS-1:0]         cnt_q, cnt_d;
  logic [COUNTER_BITS-1:0]         thr_q, thr_d;
  logic                            level_q, level_d;
  logic                            rise_q, rise_d;
  logic                            fall_q, fall_d;
  logic                            active_q, active_d;
  logic [GLITCH_BITS-1:0]          glitch_q, glitch_d;
  logic                            reject;
  logic                            cfg_unused;

  // Parameters that only shape defaults or the optional block.
  assign cfg_unused = ^{CLOCK_HZ, LONG_PRESS_CYCLES};

  // Synchronizer shift chain; the last stage is the filtered input.
  assign sync_d  = {sync_q[SYNCHRONIZE_FF_DEPTH-2:0], async_in};
  assign sync_in = sync_q[SYNCHRONIZE_FF_DEPTH-1];

  // Next-state logic: qualification FSM, edge pulses and glitch counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    thr_d    = thr_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    reject   = 1'b0;
    glitch_d = glitch_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (sync_in != level_q) begin
          state_d = S_QUALIFY;
          thr_d   = (stable_cycles > THR_MAX) ? THR_MAX : stable_cycles;
        end
      end
      S_QUALIFY: begin
        if (sync_in == level_q) begin
          // Input bounced back before the threshold elapsed.
          state_d = S_IDLE;
          cnt_d   = '0;
          reject  = 1'b1;
        end else if (cnt_q == thr_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          level_d = sync_in;
          rise_d  = sync_in;
          fall_d  = ~sync_in;
        end else begin
          cnt_d = cnt_q + COUNTER_BITS'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    active_d = (state_d == S_QUALIFY);

    // Clear wins over a same-cycle rejection.
    if (glitch_clear) begin
      glitch_d = '0;
    end else if (reject && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + GLITCH_BITS'(1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q   <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      thr_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      active_q <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      active_q <= active_d;
      glitch_q <= glitch_d;
    end
  end

  assign level         = level_q;
  assign rise          = rise_q;
  assign fall          = fall_q;
  assign filter_active = active_q;
  assign glitch_count  = glitch_q;

`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned HOLD_BITS = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [HOLD_BITS-1:0] HOLD_MAX = HOLD_BITS'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_ARM = HOLD_BITS'(LONG_PRESS_CYCLES - 2);

  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic                 long_press_q, long_press_d;

  // Hold counter: runs while pressed and settled, pauses during a release attempt.
  always_comb begin
    hold_d       = hold_q;
    long_press_d = 1'b0;
    if (fall_d) begin
      hold_d = '0;
    end else if (level_q && !active_q && (hold_q != HOLD_MAX)) begin
      hold_d       = hold_q + HOLD_BITS'(1);
      long_press_d = (hold_q == HOLD_ARM);
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold_q       <= '0;
      long_press_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      long_press_q <= long_press_d;
    end
  end

  assign long_press = long_press_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer: directed timing scenarios plus randomized
// stimulus checked against a disagreement-run reference model.

module tb_switch_debouncer;

  localparam int DEPTH = 2;
  localparam int MAXS  = 60;
  localparam int LPC   = 100;
  localparam int CB    = $clog2(MAXS + 1);

  logic          clock         = 1'b0;
  logic          reset_n       = 1'b0;
  logic          async_in      = 1'b0;
  logic [CB-1:0] stable_cycles = CB'(5);
  logic          glitch_clear  = 1'b0;
  logic          level, rise, fall, filter_active, long_press;
  logic [7:0]    glitch_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: expected outputs after the most recent edge.
  logic m_sync [DEPTH];
  int   m_run    = 0;
  int   m_thr    = 0;
  int   m_glitch = 0;
  int   m_hold   = 0;
  logic m_level  = 1'b0;
  logic m_rise   = 1'b0;
  logic m_fall   = 1'b0;
  logic m_fa     = 1'b0;
  logic m_lp     = 1'b0;

  always #5 clock = ~clock;

  switch_debouncer #(
    .SYNCHRONIZE_FF_DEPTH(DEPTH),
    .MAX_STABLE_CYCLES   (MAXS),
    .LONG_PRESS_CYCLES   (LPC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .async_in     (async_in),
    .stable_cycles(stable_cycles),
    .glitch_clear (glitch_clear),
    .level        (level),
    .rise         (rise),
    .fall         (fall),
    .filter_active(filter_active),
    .glitch_count (glitch_count),
    .long_press   (long_press)
  );

  // A change commits once the synchronized input has disagreed with level for
  // thr+2 consecutive samples; an agreeing sample mid-run is a rejected bounce.
  task automatic model_step;
    logic s;
    logic rej;
`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
    logic pl;
    logic pf;
    pl = m_level;
    pf = m_fa;
`endif
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_sync[i] = 1'b0;
      m_run = 0; m_thr = 0; m_glitch = 0; m_hold = 0;
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_fa = 1'b0; m_lp = 1'b0;
    end else begin
      s = m_sync[DEPTH-1];
      for (int i = DEPTH - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = async_in;
      m_rise = 1'b0; m_fall = 1'b0; m_lp = 1'b0; rej = 1'b0;
      if (s != m_level) begin
        if (m_run == 0) m_thr = (int'(stable_cycles) > MAXS) ? MAXS : int'(stable_cycles);
        m_run++;
        if (m_run == m_thr + 2) begin
          m_level = s;
          m_rise  = s;
          m_fall  = ~s;
          m_run   = 0;
        end
      end else begin
        rej   = (m_run != 0);
        m_run = 0;
      end
      m_fa = (m_run != 0);
      if (glitch_clear) m_glitch = 0;
      else if (rej && m_glitch < 255) m_glitch++;
`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
      if (m_fall) m_hold = 0;
      else if (pl && !pf && m_hold < LPC - 1) begin
        m_hold++;
        m_lp = (m_hold == LPC - 1);
      end
`endif
    end
  endtask

  // Advance one clock; model consumes the inputs the DUT samples at this edge.
  task automatic tick;
    model_step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; async_in = 1'b0; glitch_clear = 1'b0;
    tick(); tick();
    checks++; if (level !== 1'b0) begin failures++; $display("FAIL reset_level got=%b exp=0", level); end
    checks++; if (rise !== 1'b0) begin failures++; $display("FAIL reset_rise got=%b exp=0", rise); end
    checks++; if (fall !== 1'b0) begin failures++; $display("FAIL reset_fall got=%b exp=0", fall); end
    checks++; if (filter_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", filter_active); end
    checks++; if (glitch_count !== 8'd0) begin failures++; $display("FAIL reset_glitch got=%0d exp=0", glitch_count); end
    checks++; if (long_press !== 1'b0) begin failures++; $display("FAIL reset_long_press got=%b exp=0", long_press); end
    reset_n = 1'b1;
  endtask

  task automatic test_clean_press;
    int edge_k, fa_first, fa_last, fa_cnt;
    stable_cycles = CB'(5);
    for (int ph = 0; ph < 2; ph++) begin
      edge_k = -1; fa_first = -1; fa_last = -1; fa_cnt = 0;
      async_in = (ph == 0);
      for (int k = 1; k <= 20; k++) begin
        tick();
        checks++;
        if ({level, rise, fall, filter_active, glitch_count, long_press} !== {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp}) begin
          failures++; $display("FAIL clean_model cyc=%0d got=%h exp=%h", cyc, {level, rise, fall, filter_active, glitch_count, long_press}, {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp});
        end
        if (((ph == 0) ? rise : fall) === 1'b1 && edge_k < 0) edge_k = k;
        if (filter_active === 1'b1) begin
          if (fa_first < 0) fa_first = k;
          fa_last = k;
          fa_cnt++;
        end
      end
      checks++; if (edge_k != 9) begin failures++; $display("FAIL clean_edge ph=%0d got=%0d exp=9", ph, edge_k); end
      checks++; if (fa_first != 3 || fa_last != 8 || fa_cnt != 6) begin failures++; $display("FAIL clean_active_window ph=%0d got=%0d..%0d n=%0d exp=3..8 n=6", ph, fa_first, fa_last, fa_cnt); end
      checks++; if (level !== (ph == 0)) begin failures++; $display("FAIL clean_level ph=%0d got=%b exp=%b", ph, level, (ph == 0)); end
    end
  endtask

  task automatic test_bounce;
    logic rise_seen;
    rise_seen = 1'b0;
    stable_cycles = CB'(5);
    for (int g = 0; g < 300; g++) begin
      for (int k = 0; k < 8; k++) begin
        async_in = (k < 3);
        tick();
        checks++;
        if ({level, rise, fall, filter_active, glitch_count, long_press} !== {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp}) begin
          failures++; $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc, {level, rise, fall, filter_active, glitch_count, long_press}, {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp});
        end
        if (rise === 1'b1) rise_seen = 1'b1;
      end
      if (g == 0) begin
        checks++; if (glitch_count !== 8'd1) begin failures++; $display("FAIL bounce_count1 got=%0d exp=1", glitch_count); end
        checks++; if (level !== 1'b0) begin failures++; $display("FAIL bounce_level got=%b exp=0", level); end
      end
    end
    checks++; if (rise_seen !== 1'b0) begin failures++; $display("FAIL bounce_no_rise got=%b exp=0", rise_seen); end
    checks++; if (glitch_count !== 8'd255) begin failures++; $display("FAIL bounce_saturate got=%0d exp=255", glitch_count); end
  endtask

  task automatic test_threshold_latch;
    int edge_k;
    stable_cycles = CB'(5);
    async_in = 1'b1;
    edge_k = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if ({level, rise, fall, filter_active, glitch_count, long_press} !== {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp}) begin
        failures++; $display("FAIL latch_model cyc=%0d got=%h exp=%h", cyc, {level, rise, fall, filter_active, glitch_count, long_press}, {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp});
      end
      if (k == 5) stable_cycles = CB'(50);
      if (rise === 1'b1 && edge_k < 0) edge_k = k;
    end
    checks++; if (edge_k != 9) begin failures++; $display("FAIL latch_commit got=%0d exp=9", edge_k); end
    stable_cycles = CB'(0);
    async_in = 1'b0;
    edge_k = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (fall === 1'b1 && edge_k < 0) edge_k = k;
    end
    checks++; if (edge_k != 4) begin failures++; $display("FAIL latch_zero_latency got=%0d exp=4", edge_k); end
    checks++; if (level !== 1'b0) begin failures++; $display("FAIL latch_zero_level got=%b exp=0", level); end
    stable_cycles = CB'(5);
  endtask

  task automatic test_reset_mid;
    int edge_k;
    logic rise_seen;
    rise_seen = 1'b0;
    stable_cycles = CB'(5);
    async_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (rise === 1'b1) rise_seen = 1'b1;
    end
    checks++; if (filter_active !== 1'b1) begin failures++; $display("FAIL rstmid_qualifying got=%b exp=1", filter_active); end
    reset_n = 1'b0;
    tick();
    if (rise === 1'b1) rise_seen = 1'b1;
    checks++; if ({level, rise, fall, filter_active, glitch_count, long_press} !== 13'd0) begin
      failures++; $display("FAIL rstmid_outputs got=%h exp=0", {level, rise, fall, filter_active, glitch_count, long_press});
    end
    checks++; if (rise_seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_rise got=%b exp=0", rise_seen); end
    reset_n = 1'b1;
    edge_k = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if ({level, rise, fall, filter_active, glitch_count, long_press} !== {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp}) begin
        failures++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, {level, rise, fall, filter_active, glitch_count, long_press}, {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp});
      end
      if (rise === 1'b1 && edge_k < 0) edge_k = k;
    end
    checks++; if (edge_k != 9) begin failures++; $display("FAIL rstmid_restart got=%0d exp=9", edge_k); end
    async_in = 1'b0;
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_glitch_clear;
    glitch_clear = 1'b1;
    tick();
    glitch_clear = 1'b0;
    checks++; if (glitch_count !== 8'd0) begin failures++; $display("FAIL clear_plain got=%0d exp=0", glitch_count); end
    for (int g = 0; g < 7; g++) begin
      for (int k = 0; k < 8; k++) begin
        async_in = (k < 3);
        tick();
      end
    end
    checks++; if (glitch_count !== 8'd7) begin failures++; $display("FAIL clear_count7 got=%0d exp=7", glitch_count); end
    for (int k = 0; k < 8; k++) begin
      async_in = (k < 3);
      glitch_clear = (k == 5);
      tick();
      checks++;
      if ({level, rise, fall, filter_active, glitch_count, long_press} !== {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp}) begin
        failures++; $display("FAIL clear_model cyc=%0d got=%h exp=%h", cyc, {level, rise, fall, filter_active, glitch_count, long_press}, {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp});
      end
      if (k == 5) begin
        checks++; if (glitch_count !== 8'd0) begin failures++; $display("FAIL clear_priority got=%0d exp=0", glitch_count); end
      end
    end
    glitch_clear = 1'b0;
  endtask

  task automatic test_long_press;
    int rise_k, lp_k, lp_cnt;
    stable_cycles = CB'(5);
    for (int r = 0; r < 2; r++) begin
      rise_k = -1; lp_k = -1; lp_cnt = 0;
      async_in = 1'b1;
      for (int k = 1; k <= ((r == 0) ? 250 : 150); k++) begin
        tick();
        checks++;
        if ({level, rise, fall, filter_active, glitch_count, long_press} !== {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp}) begin
          failures++; $display("FAIL lp_model cyc=%0d got=%h exp=%h", cyc, {level, rise, fall, filter_active, glitch_count, long_press}, {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp});
        end
        if (rise === 1'b1 && rise_k < 0) rise_k = k;
        if (long_press === 1'b1) begin lp_cnt++; lp_k = k; end
      end
`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
      checks++; if (lp_cnt != 1) begin failures++; $display("FAIL lp_count r=%0d got=%0d exp=1", r, lp_cnt); end
      checks++; if (lp_k - rise_k != LPC - 1) begin failures++; $display("FAIL lp_delay r=%0d got=%0d exp=%0d", r, lp_k - rise_k, LPC - 1); end
`else
      checks++; if (lp_cnt != 0) begin failures++; $display("FAIL lp_disabled r=%0d got=%0d exp=0", r, lp_cnt); end
`endif
      async_in = 1'b0;
      for (int k = 0; k < 20; k++) tick();
    end
  endtask

  task automatic test_random;
    int   remain;
    logic prev_r, prev_f;
    remain = 0; prev_r = 1'b0; prev_f = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (remain == 0) begin
        async_in = ~async_in;
        remain = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 130)) : int'($urandom_range(1, 12));
      end
      remain--;
      if ($urandom_range(0, 7) == 0)
        stable_cycles = ($urandom_range(0, 3) == 0) ? CB'($urandom_range(0, 63)) : CB'($urandom_range(0, 6));
      glitch_clear = ($urandom_range(0, 31) == 0);
      reset_n = ($urandom_range(0, 799) != 0);
      tick();
      checks++;
      if ({level, rise, fall, filter_active, glitch_count, long_press} !== {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp}) begin
        failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, {level, rise, fall, filter_active, glitch_count, long_press}, {m_level, m_rise, m_fall, m_fa, 8'(m_glitch), m_lp});
      end
      checks++;
      if ((rise & fall) !== 1'b0 || (rise & prev_r) !== 1'b0 || (fall & prev_f) !== 1'b0) begin
        failures++; $display("FAIL random_pulse_rules cyc=%0d rise=%b fall=%b prev_rise=%b prev_fall=%b", cyc, rise, fall, prev_r, prev_f);
      end
      prev_r = rise;
      prev_f = fall;
    end
    reset_n = 1'b1;
    glitch_clear = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_sync[i] = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_threshold_latch();
    test_reset_mid();
    test_glitch_clear();
    test_long_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
